// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and types for the UART receive path:
//               parity mode encodings and the receiver state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Parity mode encodings for the PARITY parameter
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Receiver frame-tracking states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock circular-buffer FIFO with registered read data.
//               A pop on an empty FIFO is ignored; a push on a full FIFO is
//               accepted only when a pop is accepted in the same cycle.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               push, push_data - write strobe and word
//               pop             - read strobe
//               pop_data        - popped word, updated on accepted pop
//               pop_valid       - one-cycle pulse after an accepted pop
//               full, empty     - occupancy status
//               count           - number of stored words
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     pop_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [DATA_W-1:0] r_pop_data;
    logic              r_pop_valid;

    logic w_pop_ok;
    logic w_push_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_FULL);
    assign count     = r_count;
    assign pop_data  = r_pop_data;
    assign pop_valid = r_pop_valid;

    assign w_pop_ok  = pop & ~empty;
    // A full FIFO still accepts a write when a read frees a slot this cycle
    assign w_push_ok = push & (~full | w_pop_ok);

    // Storage array carries no reset; only pointers and count define contents
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            r_pop_valid <= w_pop_ok;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                r_pop_data <= r_mem[r_rd_ptr];
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receiver with framing/parity validation and a receive
//               FIFO read through a strobe interface. Sticky error flags and
//               a level interrupt are exposed for the peripheral bus.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               uart_in           - asynchronous serial line, idle high
//               rd_en             - pop one word (ignored when empty)
//               clr_err           - clear sticky error flags
//               rd_data, rd_valid - popped word and its one-cycle strobe
//               empty, full, count- FIFO status
//               frame_err, parity_err, overrun - sticky error flags
//               irq               - !empty | any error flag
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_in,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic                          irq
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

    // Two-flop synchronizer, idle-high reset so no false start after reset
    logic r_sync1;
    logic r_sync2;
    logic w_rx;

    rx_state_t r_state;
    rx_state_t w_state_next;

    logic [BAUD_W-1:0]    r_baud;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bad;
    logic                 r_frame_bad;
    logic                 r_push_req;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    logic w_half_tick;
    logic w_full_tick;
    logic w_state_change;
    logic w_baud_run;
    logic w_shift_en;
    logic w_par_sample;
    logic w_stop_sample;
    logic w_stop_done;
    logic w_par_expect;
    logic w_par_mismatch;
    logic w_push;
    logic w_frame_set;
    logic w_par_set;
    logic w_ovr_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_in;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rx = r_sync2;

    assign w_half_tick    = (r_baud == HALF_LAST);
    assign w_full_tick    = (r_baud == FULL_LAST);
    assign w_state_change = (w_state_next != r_state);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_rx) w_state_next = S_START;
            // Resample at mid start bit; a high line here was a glitch
            S_START:  if (w_half_tick) w_state_next = w_rx ? S_IDLE : S_DATA;
            S_DATA:   if (w_full_tick && (r_bit == DATA_LAST))
                          w_state_next = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
            S_PARITY: if (w_full_tick) w_state_next = S_STOP;
            S_STOP:   if (w_full_tick && (r_bit == STOP_LAST)) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // FSM output decode: which sample strobes fire this cycle
    always_comb begin
        w_baud_run    = 1'b1;
        w_shift_en    = 1'b0;
        w_par_sample  = 1'b0;
        w_stop_sample = 1'b0;
        w_stop_done   = 1'b0;
        case (r_state)
            S_IDLE:   w_baud_run = 1'b0;
            S_DATA:   w_shift_en = w_full_tick;
            S_PARITY: w_par_sample = w_full_tick;
            S_STOP: begin
                w_stop_sample = w_full_tick;
                w_stop_done   = w_full_tick && (r_bit == STOP_LAST);
            end
            default: w_baud_run = 1'b1;
        endcase
    end

    assign w_par_expect   = (PARITY == PARITY_ODD) ? ~(^r_shift) : (^r_shift);
    assign w_par_mismatch = (w_rx != w_par_expect);

    // Baud counter, bit counter, shift register and per-frame error memory
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_par_bad   <= 1'b0;
            r_frame_bad <= 1'b0;
            r_push_req  <= 1'b0;
        end else begin
            // Word is pushed the cycle after the last stop sample, only if clean
            r_push_req <= w_stop_done & ~r_par_bad & ~r_frame_bad & w_rx;

            if (!w_baud_run || w_state_change || w_full_tick) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + BAUD_W'(1);
            end

            if (w_state_change) begin
                r_bit <= '0;
            end else if (w_shift_en || w_stop_sample) begin
                r_bit <= r_bit + 4'd1;
            end

            if (w_shift_en) begin
                r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
            end

            if (r_state == S_IDLE) begin
                r_par_bad   <= 1'b0;
                r_frame_bad <= 1'b0;
            end else begin
                if (w_par_sample && w_par_mismatch) r_par_bad   <= 1'b1;
                if (w_stop_sample && !w_rx)         r_frame_bad <= 1'b1;
            end
        end
    end

    // The shift register is untouched in IDLE/START, so it still holds the
    // completed word during the push cycle even if a new frame has begun.
    assign w_push      = r_push_req & (~full | rd_en);
    assign w_ovr_set   = r_push_req & full & ~rd_en;
    assign w_frame_set = w_stop_sample & ~w_rx;
    assign w_par_set   = w_par_sample & w_par_mismatch;

    // Sticky flags: a set event in the same cycle as clr_err wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err  <= w_frame_set | (r_frame_err  & ~clr_err);
            r_parity_err <= w_par_set   | (r_parity_err & ~clr_err);
            r_overrun    <= w_ovr_set   | (r_overrun    & ~clr_err);
        end
    end

    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign irq        = ~empty | r_frame_err | r_parity_err | r_overrun;

    sync_fifo #(
        .DATA_W (DATA_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (r_shift),
        .pop       (rd_en),
        .pop_data  (rd_data),
        .pop_valid (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo, configured 8-bit, even
//               parity, one stop bit, 4 clocks per bit, 4-entry FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CPB   = 4;
    localparam int DBITS = 8;
    localparam int PAR   = 2;
    localparam int STOPB = 1;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             uart_in;
    logic             rd_en;
    logic             clr_err;
    logic [DBITS-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic [2:0]       count;
    logic             frame_err;
    logic             parity_err;
    logic             overrun;
    logic             irq;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    bit         m_frame;
    bit         m_par;
    bit         m_ovr;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DBITS),
        .PARITY       (PAR),
        .STOP_BITS    (STOPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_in    (uart_in),
        .rd_en      (rd_en),
        .clr_err    (clr_err),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input logic v);
        uart_in = v;
        repeat (CPB) tick();
    endtask

    task automatic idle_bits(input int n);
        uart_in = 1'b1;
        repeat (n * CPB) tick();
    endtask

    // Serialise one frame; optionally strobe rd_en exactly on the push edge
    task automatic send_frame(input logic [7:0] d, input bit bad_par,
                              input bit bad_stop, input bit pop_at_push);
        logic p;
        hold_bit(1'b0);
        for (int i = 0; i < DBITS; i++) hold_bit(d[i]);
        p = ^d;                        // even parity bit
        if (bad_par) p = ~p;
        hold_bit(p);
        hold_bit(~bad_stop);
        uart_in = 1'b1;
        if (pop_at_push) begin
            tick();
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
    endtask

    task automatic do_read();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        m_frame = 0; m_par = 0; m_ovr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; uart_in = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({rd_data, rd_valid, empty, full, count} !== {8'h00, 1'b0, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_fifo: got data=%h v=%b e=%b f=%b c=%0d, want 00 0 1 0 0",
                     rd_data, rd_valid, empty, full, count);
        end
        checks++;
        if ({frame_err, parity_err, overrun, irq} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b, want 0000", {frame_err, parity_err, overrun, irq});
        end
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 0, 0, 0);
        repeat (3) tick();
        checks++;
        if ({empty, count, irq} !== {1'b0, 3'd1, 1'b1}) begin
            errors++;
            $display("FAIL basic_status: got e=%b c=%0d irq=%b, want 0 1 1", empty, count, irq);
        end
        do_read();
        checks++;
        if ({rd_valid, rd_data} !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL basic_read: got v=%b d=%h, want 1 a5", rd_valid, rd_data);
        end
        checks++;
        if ({empty, irq} !== 2'b10) begin
            errors++;
            $display("FAIL basic_after_read: got e=%b irq=%b, want 1 0", empty, irq);
        end
        tick();
        checks++;
        if ({rd_valid, rd_data} !== {1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL basic_pulse: got v=%b d=%h, want 0 a5", rd_valid, rd_data);
        end
    endtask

    task automatic test_glitch();
        uart_in = 1'b0;
        tick();
        uart_in = 1'b1;
        repeat (12) tick();
        checks++;
        if ({count, frame_err, parity_err, overrun} !== {3'd0, 3'b000}) begin
            errors++;
            $display("FAIL glitch: got c=%0d flags=%b, want 0 000",
                     count, {frame_err, parity_err, overrun});
        end
        send_frame(8'h3A, 0, 0, 0);
        repeat (3) tick();
        do_read();
        checks++;
        if ({rd_valid, rd_data, empty} !== {1'b1, 8'h3A, 1'b1}) begin
            errors++;
            $display("FAIL glitch_next_frame: got v=%b d=%h e=%b, want 1 3a 1", rd_valid, rd_data, empty);
        end
    endtask

    task automatic test_parity_err();
        send_frame(8'h3C, 1, 0, 0);
        repeat (3) tick();
        checks++;
        if ({parity_err, frame_err, count, irq} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL parity_set: got p=%b f=%b c=%0d irq=%b, want 1 0 0 1",
                     parity_err, frame_err, count, irq);
        end
        do_clr();
        checks++;
        if ({parity_err, irq} !== 2'b00) begin
            errors++;
            $display("FAIL parity_clr: got p=%b irq=%b, want 0 0", parity_err, irq);
        end
    endtask

    task automatic test_frame_err();
        send_frame(8'h55, 0, 1, 0);
        idle_bits(2);
        checks++;
        if ({frame_err, parity_err, count} !== {1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL frame_set: got f=%b p=%b c=%0d, want 1 0 0", frame_err, parity_err, count);
        end
        send_frame(8'h12, 0, 0, 0);
        repeat (3) tick();
        checks++;
        if ({count, frame_err} !== {3'd1, 1'b1}) begin
            errors++;
            $display("FAIL frame_next: got c=%0d f=%b, want 1 1", count, frame_err);
        end
        do_read();
        checks++;
        if (rd_data !== 8'h12) begin
            errors++;
            $display("FAIL frame_next_data: got %h, want 12", rd_data);
        end
        do_clr();
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 0);
        repeat (3) tick();
        checks++;
        if ({full, count, overrun} !== {1'b1, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL overrun_status: got f=%b c=%0d o=%b, want 1 4 1", full, count, overrun);
        end
        for (int i = 1; i <= 4; i++) begin
            do_read();
            checks++;
            if (rd_data !== 8'(i)) begin
                errors++;
                $display("FAIL overrun_read%0d: got %h, want %h", i, rd_data, 8'(i));
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL overrun_drain: got empty=%b, want 1", empty);
        end
        do_clr();
    endtask

    task automatic test_full_pop();
        logic [7:0] w;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            w = 8'($urandom);
            exp_q.push_back(w);
            send_frame(w, 0, 0, 0);
        end
        w = 8'($urandom);
        send_frame(w, 0, 0, 1);
        checks++;
        if ({rd_valid, rd_data} !== {1'b1, exp_q[0]}) begin
            errors++;
            $display("FAIL fullpop_read: got v=%b d=%h, want 1 %h", rd_valid, rd_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        exp_q.push_back(w);
        repeat (3) tick();
        checks++;
        if ({full, count, overrun} !== {1'b1, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL fullpop_status: got f=%b c=%0d o=%b, want 1 4 0", full, count, overrun);
        end
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            do_read();
            checks++;
            if (rd_data !== w) begin
                errors++;
                $display("FAIL fullpop_drain: got %h, want %h", rd_data, w);
            end
        end
    endtask

    task automatic test_rst_mid();
        send_frame(8'h99, 0, 0, 0);
        send_frame(8'h42, 1, 0, 0);
        // Start a frame and abandon it partway through
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b0);
        rst = 1'b1;
        uart_in = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({rd_data, rd_valid, empty, full, count, frame_err, parity_err, overrun, irq}
            !== {8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 4'b0000}) begin
            errors++;
            $display("FAIL rst_mid: got d=%h v=%b e=%b f=%b c=%0d flags=%b",
                     rd_data, rd_valid, empty, full, count,
                     {frame_err, parity_err, overrun, irq});
        end
        send_frame(8'h7E, 0, 0, 0);
        repeat (3) tick();
        do_read();
        checks++;
        if ({rd_valid, rd_data, empty} !== {1'b1, 8'h7E, 1'b1}) begin
            errors++;
            $display("FAIL rst_next_frame: got v=%b d=%h e=%b, want 1 7e 1", rd_valid, rd_data, empty);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [7:0] w;
        int         kind;
        bit         prev_bad_stop;
        for (int b = 0; b < 3; b++) begin
            exp_q.delete();
            m_frame = 0; m_par = 0; m_ovr = 0;
            prev_bad_stop = 0;
            for (int f = 0; f < 6; f++) begin
                // A low stop bit needs an idle bit after it to resynchronise
                if (prev_bad_stop) idle_bits(1 + $urandom_range(0, 1));
                else idle_bits($urandom_range(0, 1));
                d    = 8'($urandom);
                kind = $urandom_range(0, 9);
                send_frame(d, kind == 7 || kind == 8, kind == 9, 0);
                prev_bad_stop = (kind == 9);
                if (kind == 7 || kind == 8) m_par = 1;
                else if (kind == 9) m_frame = 1;
                else if (exp_q.size() == DEPTH) m_ovr = 1;
                else exp_q.push_back(d);
            end
            idle_bits(2);
            checks++;
            if ({count, frame_err, parity_err, overrun} !==
                {3'(exp_q.size()), m_frame, m_par, m_ovr}) begin
                errors++;
                $display("FAIL random_status b%0d: got c=%0d fpo=%b, want c=%0d fpo=%b", b,
                         count, {frame_err, parity_err, overrun},
                         exp_q.size(), {m_frame, m_par, m_ovr});
            end
            while (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                do_read();
                checks++;
                if (rd_data !== w) begin
                    errors++;
                    $display("FAIL random_data b%0d: got %h, want %h", b, rd_data, w);
                end
            end
            do_clr();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_parity_err();
        test_frame_err();
        test_overrun();
        test_full_pop();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
